// File: rtl/seq_det_pkg.sv
// Shared constants and helpers for the programmable serial pattern detector.
// The helpers work on a 32-bit mask so that any legal MAX_LEN can slice what it needs.
package seq_det_pkg;

   localparam int MAX_LEN_MIN = 2;
   localparam int MAX_LEN_MAX = 32;

   function automatic int clamp_len(input int pat_len, input int max_len);
      return (pat_len > max_len) ? max_len : pat_len;
   endfunction

   function automatic logic [MAX_LEN_MAX-1:0] len_mask(input int len);
      logic [MAX_LEN_MAX-1:0] m;
      m = '0;
      for (int i = 0; i < MAX_LEN_MAX; i++) begin
         if (i < len) m[i] = 1'b1;
      end
      return m;
   endfunction

endpackage

// File: rtl/seq_det_history.sv
// Serial history shift register plus a saturating count of valid bits held.
// The next-state values are exported so the compare sees the completing bit in the same cycle.
module seq_det_history #(
   parameter int MAX_LEN = 8,
   parameter int FILL_W  = 4
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               shift,
   input  logic               din,
   input  logic               flush,
   input  logic               zero_fill,
   output logic [MAX_LEN-1:0] hist_next,
   output logic [FILL_W-1:0]  fill,
   output logic [FILL_W-1:0]  fill_next
);

   logic [MAX_LEN-1:0] hist;

   assign hist_next = {hist[MAX_LEN-2:0], din};
   assign fill_next = (fill == FILL_W'(MAX_LEN)) ? fill : fill + FILL_W'(1);

   // Zeroing the fill on a non-overlapping match forces the next match to use fresh bits.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         hist <= '0;
         fill <= '0;
      end else if (flush) begin
         hist <= '0;
         fill <= '0;
      end else if (shift) begin
         hist <= hist_next;
         fill <= zero_fill ? '0 : fill_next;
      end
   end

endmodule

// File: rtl/seq_detector_prog.sv
// Programmable serial bit-pattern detector: run-time pattern, length and overlap mode,
// registered one-cycle match pulse and a saturating match counter.
module seq_detector_prog
   import seq_det_pkg::*;
#(
   parameter int MAX_LEN = 8,
   parameter int LEN_W   = $clog2(MAX_LEN + 1),
   parameter int CNT_W   = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               din,
   input  logic               din_valid,
   input  logic               cfg_load,
   input  logic [MAX_LEN-1:0] pattern,
   input  logic [LEN_W-1:0]   pat_len,
   input  logic               overlap_en,
   input  logic               clear_count,
   output logic               detected,
   output logic [CNT_W-1:0]   match_count,
   output logic               armed
);

   logic [MAX_LEN-1:0] pat_sh;
   logic [LEN_W-1:0]   len_sh;
   logic               ovl_sh;

   logic               accept;
   logic               hit;
   logic [MAX_LEN-1:0] mask;
   logic [MAX_LEN-1:0] hist_next;
   logic [LEN_W-1:0]   fill;
   logic [LEN_W-1:0]   fill_next;
   logic [LEN_W-1:0]   len_eff;
   logic [LEN_W-1:0]   len_upd;
   logic [LEN_W-1:0]   fill_upd;

   assign accept  = din_valid && !cfg_load;
   assign len_eff = LEN_W'(clamp_len(int'(pat_len), MAX_LEN));
   assign mask    = MAX_LEN'(len_mask(int'(len_sh)));

   // A zero length disables matching entirely; bits above the length are ignored.
   assign hit = accept && (len_sh != '0) && (fill_next >= len_sh)
                && (((hist_next ^ pat_sh) & mask) == '0);

   assign len_upd  = cfg_load ? len_eff : len_sh;
   assign fill_upd = cfg_load ? '0
                   : accept   ? ((hit && !ovl_sh) ? '0 : fill_next)
                   : fill;

   seq_det_history #(
      .MAX_LEN (MAX_LEN),
      .FILL_W  (LEN_W)
   ) u_history (
      .clk       (clk),
      .reset     (reset),
      .shift     (accept),
      .din       (din),
      .flush     (cfg_load),
      .zero_fill (hit && !ovl_sh),
      .hist_next (hist_next),
      .fill      (fill),
      .fill_next (fill_next)
   );

   // armed is computed from next-state fill and length so it tracks the history it describes.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pat_sh      <= '0;
         len_sh      <= '0;
         ovl_sh      <= 1'b0;
         detected    <= 1'b0;
         match_count <= '0;
         armed       <= 1'b0;
      end else begin
         if (cfg_load) begin
            pat_sh <= pattern;
            len_sh <= len_eff;
            ovl_sh <= overlap_en;
         end
         detected <= hit;
         armed    <= (len_upd != '0) && (fill_upd >= len_upd);
         if (clear_count && hit)
            match_count <= CNT_W'(1);
         else if (clear_count)
            match_count <= '0;
         else if (hit && (match_count != {CNT_W{1'b1}}))
            match_count <= match_count + CNT_W'(1);
      end
   end

endmodule
